sar_sequencer: RTL and testbench
================================

Name: sar_sequencer

Overview:
- Parametrised successor to the team's fixed-frame SAR bit-decision logic.
- Sequences one complete SAR conversion per request:
  - a programmable sample phase;
  - per-bit DAC trial codes, with an optional settle wait before each comparator decision;
  - a registered result with valid/ready handshake, overrun detection and a continuous (free-running) mode.
- Sits between the comparator and capacitive DAC on one side, and the digital consumer (TMU/readout) on the other.

Parameters:
- PRECISION, 10, result width in bits; legal range 2..16.
- SAMPLE_CYCLES, 2, number of clocks sample_en is held high per conversion; must be >= 1.
- SETTLE_CYCLES, 0, extra wait clocks before each bit decision; must be >= 0.

Ports:
- clk  input  1  conversion clock.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- start  input  1  conversion request; sampled only in IDLE.
- cont  input  1  continuous mode; when 1 at end of conversion, the next conversion begins without start.
- cmp  input  1  comparator output; 1 = Vin >= Vdac (keep trial bit), 0 = clear trial bit.
- sample_en  output  1  track/hold switch control; high during SAMPLE.
- dac_code  output  PRECISION  trial code driving the DAC.
- busy  output  1  high in SAMPLE or CONVERT.
- result  output  PRECISION  last completed conversion; stable while result_valid=1 and no newer result arrives.
- result_valid  output  1  result holds unconsumed data.
- result_ready  input  1  consumer accepts result when result_valid & result_ready at a clock edge.
- overrun  output  1  sticky; a completed result overwrote an unconsumed one.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, any time, including mid-conversion) forces the following; the conversion in flight is discarded:
  - FSM to IDLE;
  - sample_en=0, dac_code=0, busy=0;
  - result=0, result_valid=0, overrun=0;
  - bit index and settle counter to 0.
- FSM states: IDLE, SAMPLE, CONVERT. All outputs are registered.
- IDLE:
  - start=1 at an edge -> SAMPLE next cycle, with sample_en=1, busy=1, dac_code=0.
  - start=0 -> remain in IDLE.
- SAMPLE:
  - lasts exactly SAMPLE_CYCLES clocks.
  - On its last edge: sample_en<=0, state<=CONVERT, bit index<=PRECISION-1, dac_code<=only MSB set.
- CONVERT:
  - Each bit occupies SETTLE_CYCLES+1 clocks.
  - cmp is sampled only on the final clock of each bit slot; cmp during settle clocks is ignored.
  - At the decision edge for bit i:
    - dac_code[i] <= cmp;
    - if i>0, dac_code[i-1] <= 1 (next trial) and the index decrements.
  - Bits above i keep their decided values.
- Completion:
  - At the bit-0 decision edge, result <= {decided upper bits, cmp} and result_valid <= 1.
  - Latency: result_valid is first high after SAMPLE_CYCLES + PRECISION*(SETTLE_CYCLES+1) edges following the edge that accepted start. Defaults give 12.
  - On that same edge:
    - if cont=1 -> SAMPLE (busy stays 1, sample_en=1, dac_code=0);
    - otherwise -> IDLE (busy=0, dac_code=0).
- start while busy is ignored and not queued.
- Changing cont mid-conversion takes effect only at completion.
- Handshake:
  - result_valid & result_ready at an edge clears result_valid, unless a new result loads on the same edge. In that case result_valid stays 1, the new value loads, and overrun is not set (the old result was consumed).
  - A new result loading while result_valid=1 and result_ready=0: overwrite result, set overrun.
- overrun:
  - overrun_clr=1 clears it.
  - If set and clear coincide, set wins.
- The result register is independent of dac_code; dac_code activity never disturbs result.

Test Plan:
- Defaults; comparator model cmp=(0x2A5 >= dac_code); start pulse for 1 clock -> sample_en high exactly 2 clocks; dac_code sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, ...; result=0x2A5 with result_valid rising 12 edges after start accepted; busy=0 afterwards.
- Boundary codes: model values 0x3FF and 0x000 -> result 0x3FF and 0x000 respectively; final dac_code before completion is 0x3FF and 0x001 respectively.
- SETTLE_CYCLES=2, model 0x155, cmp forced to the inverted value during settle clocks -> result 0x155, latency 2+10*3=32 edges.
- cont=1, result_ready=0, two conversions (0x100 then 0x0FF) -> second overwrites result=0x0FF, overrun=1; overrun_clr pulse -> overrun=0. Repeat with result_ready=1 -> overrun stays 0; the first result is consumed on the edge the second loads and result_valid stays 1.
- start asserted continuously during a conversion -> no restart; exactly one result per conversion in single mode.
- rst driven low asynchronously mid-CONVERT (between clock edges) -> all outputs 0 immediately; after release, FSM is in IDLE until start; a fresh conversion yields the correct result.

Source files
------------

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: sample phase, bit-by-bit DAC trials with optional settle wait,
// and a registered result with valid/ready handshake, overrun flag and continuous mode.
module sar_sequencer #(
   parameter int PRECISION     = 10,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cont,
   input  logic                 cmp,
   output logic                 sample_en,
   output logic [PRECISION-1:0] dac_code,
   output logic                 busy,
   output logic [PRECISION-1:0] result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int IW = $clog2(PRECISION);
   localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0]        SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES);
   localparam logic [IW-1:0]        TOP_BIT     = IW'(PRECISION - 1);
   localparam logic [PRECISION-1:0] MSB_ONLY    = {1'b1, {(PRECISION-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        sample_cnt_q, sample_cnt_d;
   logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [PRECISION-1:0] dac_code_q, dac_code_d;
   logic                 sample_en_q, sample_en_d;
   logic                 busy_q, busy_d;
   logic [PRECISION-1:0] result_q, result_d;
   logic                 result_valid_q, result_valid_d;
   logic                 overrun_q, overrun_d;
   logic                 load_result;

   always_comb begin
      state_d        = state_q;
      sample_cnt_d   = sample_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      bit_idx_d      = bit_idx_q;
      dac_code_d     = dac_code_q;
      sample_en_d    = sample_en_q;
      busy_d         = busy_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      overrun_d      = overrun_q;
      load_result    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = SAMPLE;
               sample_en_d  = 1'b1;
               busy_d       = 1'b1;
               dac_code_d   = '0;
               sample_cnt_d = '0;
            end
         end
         SAMPLE: begin
            if (sample_cnt_q == SAMPLE_LAST) begin
               state_d      = CONVERT;
               sample_en_d  = 1'b0;
               bit_idx_d    = TOP_BIT;
               dac_code_d   = MSB_ONLY;
               settle_cnt_d = '0;
            end else begin
               sample_cnt_d = sample_cnt_q + 1'b1;
            end
         end
         CONVERT: begin
            // cmp only matters on the last clock of each bit slot; earlier clocks let the DAC settle
            if (settle_cnt_q != SETTLE_LAST) begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end else begin
               settle_cnt_d = '0;
               if (bit_idx_q != '0) begin
                  dac_code_d[bit_idx_q]        = cmp;
                  dac_code_d[bit_idx_q - 1'b1] = 1'b1;
                  bit_idx_d                    = bit_idx_q - 1'b1;
               end else begin
                  load_result  = 1'b1;
                  result_d     = {dac_code_q[PRECISION-1:1], cmp};
                  dac_code_d   = '0;
                  sample_cnt_d = '0;
                  if (cont) begin
                     state_d     = SAMPLE;
                     sample_en_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_d     = IDLE;
            sample_en_d = 1'b0;
            busy_d      = 1'b0;
            dac_code_d  = '0;
         end
      endcase

      // A result consumed on the same edge a new one lands is not an overrun
      if (load_result) begin
         result_valid_d = 1'b1;
      end else if (result_valid_q && result_ready) begin
         result_valid_d = 1'b0;
      end

      if (load_result && result_valid_q && !result_ready) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         sample_cnt_q   <= '0;
         settle_cnt_q   <= '0;
         bit_idx_q      <= '0;
         dac_code_q     <= '0;
         sample_en_q    <= 1'b0;
         busy_q         <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         sample_cnt_q   <= sample_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         bit_idx_q      <= bit_idx_d;
         dac_code_q     <= dac_code_d;
         sample_en_q    <= sample_en_d;
         busy_q         <= busy_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   assign sample_en    = sample_en_q;
   assign dac_code     = dac_code_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: a default-parameter instance and a SETTLE_CYCLES=2 instance,
// driven by comparator models; results are checked by scoreboard monitors on each handshake.
module tb_sar_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       start_a, cont_a, cmp_a, ready_a, clr_a;
   logic       sample_en_a, busy_a, valid_a, overrun_a;
   logic [9:0] dac_a, result_a, model_a;

   logic       start_b, cont_b, cmp_b, ready_b, clr_b;
   logic       sample_en_b, busy_b, valid_b, overrun_b;
   logic [9:0] dac_b, result_b, model_b;
   int         slot_b;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_a[$];
   logic [9:0] exp_b[$];

   sar_sequencer dut_a (
      .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .cmp(cmp_a),
      .sample_en(sample_en_a), .dac_code(dac_a), .busy(busy_a),
      .result(result_a), .result_valid(valid_a), .result_ready(ready_a),
      .overrun(overrun_a), .overrun_clr(clr_a)
   );

   sar_sequencer #(.PRECISION(10), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .cmp(cmp_b),
      .sample_en(sample_en_b), .dac_code(dac_b), .busy(busy_b),
      .result(result_b), .result_valid(valid_b), .result_ready(ready_b),
      .overrun(overrun_b), .overrun_clr(clr_b)
   );

   assign cmp_a = (model_a >= dac_a);

   // Comparator for the settle instance lies (inverted) on every clock except decision clocks
   always_comb begin
      if (slot_b >= 4 && ((slot_b - 1) % 3) == 0) cmp_b = (model_b >= dac_b);
      else                                         cmp_b = !(model_b >= dac_b);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && valid_a && ready_a) begin
         if (exp_a.size() == 0) checkOutput("unexpected_result_a", 32'd1, 32'd0);
         else                   checkOutput("result_a", result_a, exp_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && valid_b && ready_b) begin
         if (exp_b.size() == 0) checkOutput("unexpected_result_b", 32'd1, 32'd0);
         else                   checkOutput("result_b", result_b, exp_b.pop_front());
      end
   end

   task automatic applyStimulus(input logic [9:0] val, input bit hold_start,
                                input logic [9:0] exp_last_dac, input bit check_seq);
      int k;
      int sen;
      logic [9:0] last_dac;
      logic [9:0] codes[16];
      logic [9:0] seq[5];
      seq = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0};
      model_a = val;
      exp_a.push_back(val);
      start_a = 1'b1;
      @(posedge clk); #1;
      k = 0;
      sen = sample_en_a ? 1 : 0;
      codes[0] = dac_a;
      last_dac = dac_a;
      if (!hold_start) start_a = 1'b0;
      while (!valid_a && k < 100) begin
         last_dac = dac_a;
         @(posedge clk); #1;
         k++;
         if (sample_en_a) sen++;
         if (k < 16) codes[k] = dac_a;
         if (hold_start && k == 10) start_a = 1'b0;
      end
      start_a = 1'b0;
      checkOutput("latency", k, 12);
      checkOutput("sample_en_cycles", sen, 2);
      checkOutput("final_trial", last_dac, exp_last_dac);
      checkOutput("busy_after", busy_a, 0);
      checkOutput("dac_after", dac_a, 0);
      if (check_seq) begin
         for (int i = 0; i < 5; i++) checkOutput("dac_seq", codes[i+2], seq[i]);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b0;
      start_a = 0; cont_a = 0; ready_a = 1; clr_a = 0; model_a = 10'h0;
      start_b = 0; cont_b = 0; ready_b = 1; clr_b = 0; model_b = 10'h155;
      slot_b = -1;
      repeat (2) @(posedge clk); #1;
      checkOutput("rst_sample_en", sample_en_a, 0);
      checkOutput("rst_dac", dac_a, 0);
      checkOutput("rst_busy", busy_a, 0);
      checkOutput("rst_result", result_a, 0);
      checkOutput("rst_valid", valid_a, 0);
      checkOutput("rst_overrun", overrun_a, 0);
      checkOutput("rst_busy_b", busy_b, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      checkOutput("idle_busy", busy_a, 0);

      $display("[TB] basic conversion 0x2A5");
      applyStimulus(10'h2A5, 1'b0, 10'h2A5, 1'b1);
      $display("[TB] boundary codes");
      applyStimulus(10'h3FF, 1'b0, 10'h3FF, 1'b0);
      applyStimulus(10'h000, 1'b0, 10'h001, 1'b0);

      $display("[TB] start held during conversion");
      applyStimulus(10'h1C3, 1'b1, 10'h1C3, 1'b0);
      repeat (20) @(posedge clk); #1;
      checkOutput("no_restart_busy", busy_a, 0);
      checkOutput("one_result_only", exp_a.size(), 0);

      $display("[TB] settle instance");
      begin
         int k;
         exp_b.push_back(10'h155);
         start_b = 1'b1;
         @(posedge clk); #1;
         slot_b = 0;
         start_b = 1'b0;
         k = 0;
         while (!valid_b && k < 200) begin
            @(posedge clk); #1;
            k++;
            slot_b = k;
         end
         checkOutput("settle_latency", k, 32);
         @(posedge clk); #1;
         slot_b = -1;
         checkOutput("settle_busy_after", busy_b, 0);
      end

      $display("[TB] continuous mode, no consumer");
      ready_a = 1'b0; cont_a = 1'b1; model_a = 10'h100;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (12) @(posedge clk); #1;
      model_a = 10'h0FF;
      checkOutput("cont_first_valid", valid_a, 1);
      checkOutput("cont_first_result", result_a, 10'h100);
      checkOutput("cont_busy", busy_a, 1);
      checkOutput("cont_resample", sample_en_a, 1);
      checkOutput("cont_no_overrun", overrun_a, 0);
      @(posedge clk); #1;
      cont_a = 1'b0;
      repeat (10) @(posedge clk); #1;
      clr_a = 1'b1;
      @(posedge clk); #1;
      checkOutput("overwrite_result", result_a, 10'h0FF);
      checkOutput("overwrite_valid", valid_a, 1);
      checkOutput("overrun_set_wins", overrun_a, 1);
      checkOutput("cont_stops_busy", busy_a, 0);
      @(posedge clk); #1;
      clr_a = 1'b0;
      checkOutput("overrun_cleared", overrun_a, 0);
      checkOutput("valid_kept", valid_a, 1);
      exp_a.push_back(10'h0FF);
      ready_a = 1'b1;
      @(posedge clk); #1;
      checkOutput("consumed_valid", valid_a, 0);

      $display("[TB] continuous mode, consume on load edge");
      ready_a = 1'b0; cont_a = 1'b1; model_a = 10'h100;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (12) @(posedge clk); #1;
      model_a = 10'h0FF;
      exp_a.push_back(10'h100);
      checkOutput("cont2_first_valid", valid_a, 1);
      @(posedge clk); #1;
      cont_a = 1'b0;
      repeat (10) @(posedge clk); #1;
      ready_a = 1'b1;
      @(posedge clk); #1;
      ready_a = 1'b0;
      checkOutput("cont2_valid_stays", valid_a, 1);
      checkOutput("cont2_result", result_a, 10'h0FF);
      checkOutput("cont2_no_overrun", overrun_a, 0);
      exp_a.push_back(10'h0FF);
      ready_a = 1'b1;
      @(posedge clk); #1;
      checkOutput("cont2_consumed", valid_a, 0);

      $display("[TB] async reset mid-conversion");
      model_a = 10'h2A5;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (7) @(posedge clk); #1;
      checkOutput("pre_reset_busy", busy_a, 1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_sample_en", sample_en_a, 0);
      checkOutput("arst_dac", dac_a, 0);
      checkOutput("arst_busy", busy_a, 0);
      checkOutput("arst_result", result_a, 0);
      checkOutput("arst_valid", valid_a, 0);
      checkOutput("arst_overrun", overrun_a, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) @(posedge clk); #1;
      checkOutput("post_reset_idle_busy", busy_a, 0);
      checkOutput("post_reset_idle_sample", sample_en_a, 0);
      checkOutput("post_reset_valid", valid_a, 0);
      applyStimulus(10'h2A5, 1'b0, 10'h2A5, 1'b0);

      repeat (3) @(posedge clk); #1;
      checkOutput("queue_a_drained", exp_a.size(), 0);
      checkOutput("queue_b_drained", exp_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
